// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: memory access modes, arbiter
// ownership states and the requester count.
package memory_arbiter_pkg;

  typedef enum logic [2:0] {
    ReadWriteMode_NONE      = 3'd0,
    ReadWriteMode_BYTE      = 3'd1,
    ReadWriteMode_HALFWORD  = 3'd2,
    ReadWriteMode_WORD      = 3'd3,
    ReadWriteMode_WORDLEFT  = 3'd4,
    ReadWriteMode_WORDRIGHT = 3'd5
  } ReadWriteMode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } ArbiterOwner_t;

  localparam int NUM_MEM_REQUESTERS = 2;
  localparam int BURST_W            = 4;

  // Ownership state that corresponds to a requester index.
  function automatic ArbiterOwner_t owner_of(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational grant decision: round-robin between two requesters with a
// bounded burst lock for the current owner.
module memory_arbiter_pick
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [NUM_MEM_REQUESTERS-1:0] valid,
  input  ArbiterOwner_t                 owner,
  input  logic [BURST_W-1:0]            burst_count,
  input  logic                          last_served,
  output logic [NUM_MEM_REQUESTERS-1:0] grant
);

  localparam logic [BURST_W-1:0] MAX_BURST_L = BURST_W'(MAX_BURST);

  logic burst_open;

  // Pick the one-hot winner for this cycle.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant      = '0;
    burst_open = (burst_count < MAX_BURST_L);
    unique case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (owner == OWN0 && burst_open)      grant = 2'b01;
        else if (owner == OWN1 && burst_open) grant = 2'b10;
        else                                  grant = last_served ? 2'b01 : 2'b10;
      end
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the shared Memory data port. Forwards the granted
// request combinationally and registers load data back to the winner.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MEM_REQUESTERS-1:0]       reqValid,
  input  logic [NUM_MEM_REQUESTERS-1:0][31:0] reqAddress,
  input  logic [NUM_MEM_REQUESTERS-1:0][31:0] reqData,
  input  logic [NUM_MEM_REQUESTERS-1:0][2:0]  reqWriteMode,
  input  logic [NUM_MEM_REQUESTERS-1:0][2:0]  reqReadMode,
  input  logic [NUM_MEM_REQUESTERS-1:0]       reqUnsignedLoad,
  output logic [NUM_MEM_REQUESTERS-1:0]       reqReady,
  output logic [NUM_MEM_REQUESTERS-1:0]       rspValid,
  output logic [NUM_MEM_REQUESTERS-1:0][31:0] rspData,
  output logic [31:0]                         memAddress,
  output logic [31:0]                         memData,
  output logic [2:0]                          memWriteMode,
  output logic [2:0]                          memReadMode,
  output logic                                memUnsignedLoad,
  input  logic [31:0]                         memDataOutput
);

  localparam logic [BURST_W-1:0] MAX_BURST_L = BURST_W'(MAX_BURST);

  ArbiterOwner_t                         owner_q, owner_d;
  logic                                  last_served_q, last_served_d;
  logic [BURST_W-1:0]                    burst_count_q, burst_count_d;
  logic [NUM_MEM_REQUESTERS-1:0]         rsp_valid_q, rsp_valid_d;
  logic [NUM_MEM_REQUESTERS-1:0][31:0]   rsp_data_q, rsp_data_d;
  logic [NUM_MEM_REQUESTERS-1:0]         grant_raw, grant;
  logic                                  sel;

  memory_arbiter_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .valid       (reqValid),
    .owner       (owner_q),
    .burst_count (burst_count_q),
    .last_served (last_served_q),
    .grant       (grant_raw)
  );

  // Reset masks the grant so nothing reaches Memory while rst is high.
  assign grant    = rst ? '0 : grant_raw;
  assign sel      = grant[1];
  assign reqReady = grant;
  assign rspValid = rsp_valid_q;
  assign rspData  = rsp_data_q;

  // Forward the winning request to Memory, or an idle beat when nobody wins.
  always_comb begin
    memAddress      = '0;
    memData         = '0;
    memWriteMode    = ReadWriteMode_NONE;
    memReadMode     = ReadWriteMode_NONE;
    memUnsignedLoad = 1'b0;
    if (grant != '0) begin
      memAddress      = reqAddress[sel];
      memData         = reqData[sel];
      memWriteMode    = reqWriteMode[sel];
      memReadMode     = reqReadMode[sel];
      memUnsignedLoad = reqUnsignedLoad[sel];
    end
  end

  // Ownership, fairness and burst bookkeeping plus load-response capture.
  always_comb begin
    owner_d       = owner_q;
    last_served_d = last_served_q;
    burst_count_d = burst_count_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    if (grant != '0) begin
      last_served_d = sel;
      if (owner_q == owner_of(sel)) begin
        burst_count_d = (burst_count_q >= MAX_BURST_L) ? burst_count_q
                                                       : burst_count_q + 1'b1;
      end else begin
        owner_d       = owner_of(sel);
        burst_count_d = BURST_W'(1);
      end
    end else begin
      owner_d       = IDLE;
      burst_count_d = '0;
    end
    for (int k = 0; k < NUM_MEM_REQUESTERS; k++) begin
      if (grant[k] && reqReadMode[k] != ReadWriteMode_NONE) begin
        rsp_valid_d[k] = 1'b1;
        rsp_data_d[k]  = memDataOutput;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      owner_q       <= IDLE;
      last_served_q <= 1'b1;
      burst_count_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      burst_count_q <= burst_count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random
// traffic, a behavioural grant/memory model and a response scoreboard.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        reqValid = '0;
  logic [1:0][31:0]  reqAddress = '0;
  logic [1:0][31:0]  reqData = '0;
  logic [1:0][2:0]   reqWriteMode = '0;
  logic [1:0][2:0]   reqReadMode = '0;
  logic [1:0]        reqUnsignedLoad = '0;
  logic [1:0]        reqReady;
  logic [1:0]        rspValid;
  logic [1:0][31:0]  rspData;
  logic [31:0]       memAddress, memData, memDataOutput;
  logic [2:0]        memWriteMode, memReadMode;
  logic              memUnsignedLoad;

  always #5 clk = ~clk;

  memory_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk             (clk),
    .rst             (rst),
    .reqValid        (reqValid),
    .reqAddress      (reqAddress),
    .reqData         (reqData),
    .reqWriteMode    (reqWriteMode),
    .reqReadMode     (reqReadMode),
    .reqUnsignedLoad (reqUnsignedLoad),
    .reqReady        (reqReady),
    .rspValid        (rspValid),
    .rspData         (rspData),
    .memAddress      (memAddress),
    .memData         (memData),
    .memWriteMode    (memWriteMode),
    .memReadMode     (memReadMode),
    .memUnsignedLoad (memUnsignedLoad),
    .memDataOutput   (memDataOutput)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  wm;
    logic [2:0]  rm;
    logic        us;
  } req_t;

  typedef struct {
    int          due;
    int          k;
    logic [31:0] data;
  } rsp_t;

  localparam req_t NO_REQ = '0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  rsp_t        exp_q[$];
  logic [31:0] held [2];
  logic [31:0] ref_mem [64];
  logic [31:0] stub_mem [64];
  int          ref_own, ref_run, ref_last, last_grant;

  // Little-endian lane merge / load formatting shared by the Memory stand-in
  // and the reference memory.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [2:0] mode);
    logic [31:0] w;
    w = old;
    case (mode)
      ReadWriteMode_BYTE:     w[{addr[1:0], 3'b000} +: 8] = data[7:0];
      ReadWriteMode_HALFWORD: w[{addr[1], 4'b0000} +: 16] = data[15:0];
      ReadWriteMode_WORD:     w = data;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] mode, input logic us);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {addr[1:0], 3'b000});
    h = 16'(word >> {addr[1], 4'b0000});
    case (mode)
      ReadWriteMode_BYTE:     return us ? {24'b0, b} : {{24{b[7]}}, b};
      ReadWriteMode_HALFWORD: return us ? {16'b0, h} : {{16{h[15]}}, h};
      ReadWriteMode_WORD:     return word;
      default:                return 32'h0;
    endcase
  endfunction

  // Memory stand-in: combinational read, store commits at the clock edge.
  assign memDataOutput = load_extract(stub_mem[memAddress[7:2]], memAddress, memReadMode, memUnsignedLoad);
  always @(posedge clk)
    if (memWriteMode != 3'd0)
      stub_mem[memAddress[7:2]] <= store_merge(stub_mem[memAddress[7:2]], memAddress, memData, memWriteMode);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration rule.
  function automatic int ref_pick(input logic v0, input logic v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (!v0 && v1)  return 1;
    if (ref_own >= 0 && ref_run < MAX_BURST) return ref_own;
    return 1 - ref_last;
  endfunction

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                              input logic [2:0] r, input logic u);
    req_t q;
    q = '{valid: 1'b1, addr: a, data: d, wm: w, rm: r, us: u};
    return q;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   s;
    s      = $urandom_range(1, 3);
    r.valid = 1'b1;
    r.addr = 32'h0000_FFC0 + 32'($urandom_range(0, 15)) * 4;
    if (s == 1)      r.addr = r.addr + 32'($urandom_range(0, 3));
    else if (s == 2) r.addr = r.addr + 32'($urandom_range(0, 1)) * 2;
    r.data = $urandom;
    r.wm   = ($urandom_range(0, 1) == 1) ? 3'(s) : 3'd0;
    r.rm   = ($urandom_range(0, 1) == 1) ? 3'(s) : 3'd0;
    r.us   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One clock cycle: drive, check the combinational grant/forwarding, then
  // advance the reference model and queue any expected load response.
  task automatic do_cycle(input req_t r0, input req_t r1, input logic rst_i, output int g_act);
    req_t        rq [2];
    int          g;
    logic [1:0]  exp_rdy;
    logic [70:0] exp_bus;
    @(posedge clk);
    #1;
    rst             = rst_i;
    reqValid        = {r1.valid, r0.valid};
    reqAddress      = {r1.addr, r0.addr};
    reqData         = {r1.data, r0.data};
    reqWriteMode    = {r1.wm, r0.wm};
    reqReadMode     = {r1.rm, r0.rm};
    reqUnsignedLoad = {r1.us, r0.us};
    #5;
    rq[0] = r0;
    rq[1] = r1;
    g = rst_i ? -1 : ref_pick(r0.valid, r1.valid);
    exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    exp_bus = (g < 0) ? '0 : {rq[g].addr, rq[g].data, rq[g].wm, rq[g].rm, rq[g].us};
    check("reqReady", reqReady, exp_rdy);
    check("mem_bus", {memAddress, memData, memWriteMode, memReadMode, memUnsignedLoad}, exp_bus);
    g_act = reqReady[1] ? 1 : (reqReady[0] ? 0 : -1);
    if (rst_i) begin
      ref_own = -1; ref_run = 0; ref_last = 1;
      held[0] = '0; held[1] = '0;
    end else if (g < 0) begin
      ref_own = -1; ref_run = 0;
    end else begin
      if (rq[g].rm != 3'd0)
        exp_q.push_back('{due: cyc + 1, k: g,
                          data: load_extract(ref_mem[rq[g].addr[7:2]], rq[g].addr, rq[g].rm, rq[g].us)});
      if (rq[g].wm != 3'd0)
        ref_mem[rq[g].addr[7:2]] = store_merge(ref_mem[rq[g].addr[7:2]], rq[g].addr, rq[g].data, rq[g].wm);
      if (g == ref_own) ref_run = (ref_run < MAX_BURST) ? ref_run + 1 : ref_run;
      else begin ref_own = g; ref_run = 1; end
      ref_last = g;
    end
    last_grant = g;
  endtask

  // Response monitor: pops the scoreboard whenever a response is due.
  bit have_exp;
  int exp_k;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        have_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_k    = have_exp ? exp_q[0].k : -1;
        for (int k = 0; k < 2; k++) begin
          check($sformatf("rspValid[%0d]", k), rspValid[k], (exp_k == k));
          if (exp_k == k) begin
            check($sformatf("rspData[%0d]", k), rspData[k], exp_q[0].data);
            held[k] = exp_q[0].data;
          end else begin
            check($sformatf("rspData_hold[%0d]", k), rspData[k], held[k]);
          end
        end
        if (have_exp) void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus.
  initial begin
    int         g;
    bit [11:0]  seq;
    req_t       cur [2];
    logic       rst_i;
    for (int i = 0; i < 64; i++) begin
      stub_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    ref_own = -1; ref_run = 0; ref_last = 1; last_grant = -1;
    held[0] = '0; held[1] = '0;

    repeat (2) do_cycle(NO_REQ, NO_REQ, 1'b1, g);
    mon_en = 1'b1;

    // Requester 0 alone: word store then word load at 65532.
    do_cycle(mk(32'd65532, 32'h2234_5678, ReadWriteMode_WORD, ReadWriteMode_NONE, 1'b0), NO_REQ, 1'b0, g);
    do_cycle(mk(32'd65532, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), NO_REQ, 1'b0, g);
    do_cycle(NO_REQ, NO_REQ, 1'b0, g);

    // Continuous contention from reset: bursts of MAX_BURST alternate.
    do_cycle(NO_REQ, NO_REQ, 1'b1, g);
    seq = '0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(mk(32'hFFE0, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0),
               mk(32'hFFE4, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), 1'b0, g);
      seq = {seq[10:0], (g == 1)};
    end
    check("burst_sequence", seq, 12'b0000_1111_0000);

    // Requester 1 owns with two beats, then drops while 0 waits.
    do_cycle(NO_REQ, mk(32'hFFD0, 32'h0, ReadWriteMode_NONE, ReadWriteMode_NONE, 1'b0), 1'b0, g);
    do_cycle(mk(32'hFFD4, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0),
             mk(32'hFFD0, 32'h0, ReadWriteMode_NONE, ReadWriteMode_NONE, 1'b0), 1'b0, g);
    do_cycle(mk(32'hFFD4, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), NO_REQ, 1'b0, g);
    check("drop_handover", g, 0);
    do_cycle(mk(32'hFFD4, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0),
             mk(32'hFFD0, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), 1'b0, g);
    check("new_owner_keeps", g, 0);

    // Requester 1 halfword store then unsigned and signed halfword loads.
    do_cycle(NO_REQ, mk(32'd65528, 32'h0000_FFFF, ReadWriteMode_HALFWORD, ReadWriteMode_NONE, 1'b0), 1'b0, g);
    do_cycle(NO_REQ, mk(32'd65528, 32'h0, ReadWriteMode_NONE, ReadWriteMode_HALFWORD, 1'b1), 1'b0, g);
    do_cycle(NO_REQ, mk(32'd65528, 32'h0, ReadWriteMode_NONE, ReadWriteMode_HALFWORD, 1'b0), 1'b0, g);

    // Store during reset must not commit; first tie afterwards goes to 0.
    do_cycle(mk(32'd65532, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), NO_REQ, 1'b0, g);
    do_cycle(mk(32'd65528, 32'hABCD_0000, ReadWriteMode_WORD, ReadWriteMode_NONE, 1'b0), NO_REQ, 1'b1, g);
    do_cycle(mk(32'd65528, 32'h0, ReadWriteMode_NONE, ReadWriteMode_WORD, 1'b0), NO_REQ, 1'b0, g);
    do_cycle(NO_REQ, NO_REQ, 1'b1, g);
    do_cycle(mk(32'hFFC0, 32'h0, ReadWriteMode_NONE, ReadWriteMode_NONE, 1'b0),
             mk(32'hFFC4, 32'h0, ReadWriteMode_NONE, ReadWriteMode_NONE, 1'b0), 1'b0, g);
    check("first_tie_after_reset", g, 0);

    // Idle interval.
    repeat (5) do_cycle(NO_REQ, NO_REQ, 1'b0, g);

    // Random traffic honouring the hold-while-waiting rule.
    cur[0] = NO_REQ;
    cur[1] = NO_REQ;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (cur[k].valid && last_grant != k) begin
          if ($urandom_range(0, 4) == 0) cur[k].valid = 1'b0;
        end else begin
          cur[k] = rand_req();
          if ($urandom_range(0, 3) == 0) cur[k].valid = 1'b0;
        end
      end
      rst_i = ($urandom_range(0, 99) == 0);
      do_cycle(cur[0], cur[1], rst_i, g);
    end

    repeat (3) do_cycle(NO_REQ, NO_REQ, 1'b0, g);
    check("rsp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
